// File: rtl/match_sequencer.sv
// match_sequencer: walks an input string by repeatedly launching the vocab matcher and
// emitting one token per match (vocab index or UNK_ID) on a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | m_start pulse at current ptr, watchdog loaded
// WAIT   | waiting for m_done or watchdog expiry
// EMIT   | token presented, holding until tok_ready
// FINISH | done pulse; busy drops on the following cycle
module match_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int UNK_ID     = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   in_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_start,
    output logic [ADDR_WIDTH-1:0] m_in_addr,
    input  logic                  m_done,
    input  logic                  m_found,
    input  logic [ADDR_WIDTH-1:0] m_vocab_idx,
    input  logic [ADDR_WIDTH:0]   m_match_len,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic [ADDR_WIDTH-1:0] tok_id,
    output logic                  tok_last
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int PW     = ADDR_WIDTH + 1;
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0]     WDOG_LOAD = WDOG_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] UNK_TOK   = ADDR_WIDTH'(UNK_ID);

    // RAM data never enters this block; the width only has to be legal for the parent.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
    end

    logic [2:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         len_q, len_d;
    logic [PW-1:0]         next_ptr_q, next_ptr_d;
    logic [ADDR_WIDTH-1:0] tok_id_q, tok_id_d;
    logic                  tok_last_q, tok_last_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;

    logic                  hit;
    logic [PW-1:0]         adv;
    logic [PW:0]           sum;
    logic                  at_end;
    logic [PW-1:0]         clamped;

    always_comb begin
        // a zero-length hit counts as a miss so every match advances by at least one
        hit     = m_done && m_found && (m_match_len != '0);
        adv     = hit ? m_match_len : PW'(1);
        sum     = {1'b0, ptr_q} + {1'b0, adv};
        at_end  = (sum >= {1'b0, len_q});
        clamped = at_end ? len_q : sum[PW-1:0];

        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        next_ptr_d = next_ptr_q;
        tok_id_d   = tok_id_q;
        tok_last_d = tok_last_q;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = in_len;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (in_len == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = WDOG_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done || (wdog_q == '0)) begin
                    tok_id_d   = hit ? m_vocab_idx : UNK_TOK;
                    next_ptr_d = clamped;
                    tok_last_d = at_end;
                    err_d      = err_q | ~m_done;
                    state_d    = S_EMIT;
                end else begin
                    wdog_d = wdog_q - 1'b1;
                end
            end
            S_EMIT: begin
                if (tok_ready) begin
                    ptr_d   = next_ptr_q;
                    state_d = tok_last_q ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            len_q      <= '0;
            next_ptr_q <= '0;
            tok_id_q   <= '0;
            tok_last_q <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            next_ptr_q <= next_ptr_d;
            tok_id_q   <= tok_id_d;
            tok_last_q <= tok_last_d;
            wdog_q     <= wdog_d;
        end
    end

    assign busy      = busy_q;
    assign err       = err_q;
    assign done      = (state_q == S_FINISH);
    assign m_start   = (state_q == S_LAUNCH);
    assign m_in_addr = ptr_q[ADDR_WIDTH-1:0];
    assign tok_valid = (state_q == S_EMIT);
    assign tok_id    = tok_id_q;
    assign tok_last  = tok_last_q && tok_valid;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized scoreboard bench for match_sequencer: a matcher responder feeds an
// arithmetic token model into a queue; a monitor pops and compares on each handshake.
module tb_match_sequencer;

    localparam int AW  = 4;
    localparam int LW  = AW + 1;
    localparam int UNK = 14;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] in_len;
    logic          busy, done, err, m_start;
    logic [AW-1:0] m_in_addr;
    logic          m_done, m_found;
    logic [AW-1:0] m_vocab_idx;
    logic [LW-1:0] m_match_len;
    logic          tok_valid, tok_ready;
    logic [AW-1:0] tok_id;
    logic          tok_last;

    match_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .UNK_ID(UNK), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_len(in_len),
        .busy(busy), .done(done), .err(err),
        .m_start(m_start), .m_in_addr(m_in_addr),
        .m_done(m_done), .m_found(m_found), .m_vocab_idx(m_vocab_idx), .m_match_len(m_match_len),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_id(tok_id), .tok_last(tok_last)
    );

    always #5 clk = ~clk;

    typedef struct { int lat; bit found; int idx; int len; } resp_t;
    typedef struct { int id; bit last; } tok_t;

    resp_t script_q[$];
    tok_t  sb_q[$];
    int    checks = 0;
    int    failures = 0;
    int    model_ptr = 0;
    int    model_len = 0;
    bit    exp_err = 1'b0;
    int    starts_seen = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    bit    allow_timeout = 1'b0;
    bit    stray_en = 1'b0;
    int    ready_mode = 1;

    always @(posedge clk) cyc++;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    function automatic resp_t rand_resp();
        resp_t r;
        r.lat   = $urandom_range(0, 4);
        if (allow_timeout && $urandom_range(0, 19) == 0) r.lat = -1;
        r.found = ($urandom_range(0, 3) != 0);
        r.idx   = $urandom_range(0, 15);
        r.len   = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 4);
        return r;
    endfunction

    // downstream ready: changed just after posedge so it is settled for both monitor and DUT
    initial begin
        tok_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       tok_ready = 1'b0;
                1:       tok_ready = 1'b1;
                default: tok_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // matcher responder + reference model of the token stream
    initial begin
        resp_t r;
        tok_t  t;
        bit    hit;
        int    adv, np, cnt;
        m_done = 1'b0; m_found = 1'b0; m_vocab_idx = '0; m_match_len = '0;
        forever begin
            @(negedge clk);
            if (!rst && m_start) begin
                starts_seen++;
                if (model_ptr >= model_len) fail_now("extra_m_start");
                check("m_in_addr", int'(m_in_addr), model_ptr % 16);
                r = (script_q.size() > 0) ? script_q.pop_front() : rand_resp();
                hit = (r.lat >= 0) && r.found && (r.len != 0);
                adv = hit ? r.len : 1;
                np  = (model_ptr + adv > model_len) ? model_len : model_ptr + adv;
                t.id   = hit ? r.idx : UNK;
                t.last = (np >= model_len);
                sb_q.push_back(t);
                model_ptr = np;
                if (r.lat < 0) exp_err = 1'b1;
                @(negedge clk);
                check("m_start_pulse", int'(m_start), 0);
                if (r.lat < 0) begin
                    cnt = 1;
                    while (!tok_valid && cnt < 100 && !rst) begin
                        @(negedge clk);
                        cnt++;
                    end
                    if (!rst) check("timeout_wait", cnt, TMO + 1);
                end else begin
                    repeat (r.lat) @(negedge clk);
                    m_done = 1'b1; m_found = r.found;
                    m_vocab_idx = AW'(r.idx); m_match_len = LW'(r.len);
                    @(negedge clk);
                    m_done = 1'b0; m_found = 1'($urandom); m_vocab_idx = AW'($urandom);
                    m_match_len = LW'($urandom);
                    if (!rst) check("token_latency", int'(tok_valid), 1);
                    if (stray_en) begin
                        repeat (2) @(negedge clk);
                        m_done = 1'b1; m_found = 1'b1; m_vocab_idx = 4'd15; m_match_len = 5'd1;
                        @(negedge clk);
                        m_done = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: pops the scoreboard on handshakes, checks stability while stalled
    initial begin
        tok_t t;
        bit   stall_prev = 1'b0;
        int   prev_id = 0;
        bit   prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (tok_valid && stall_prev) begin
                    check("stall_tok_id", int'(tok_id), prev_id);
                    check("stall_tok_last", int'(tok_last), int'(prev_last));
                end
                if (tok_valid && tok_ready) begin
                    last_hs_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_token");
                    end else begin
                        t = sb_q.pop_front();
                        check("tok_id", int'(tok_id), t.id);
                        check("tok_last", int'(tok_last), int'(t.last));
                    end
                    stall_prev = 1'b0;
                end else if (tok_valid) begin
                    check("stall_no_m_start", int'(m_start), 0);
                    stall_prev = 1'b1;
                    prev_id    = int'(tok_id);
                    prev_last  = tok_last;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_m_start"}, int'(m_start), 0);
        check({tag, "_m_in_addr"}, int'(m_in_addr), 0);
        check({tag, "_tok_valid"}, int'(tok_valid), 0);
        check({tag, "_tok_id"}, int'(tok_id), 0);
        check({tag, "_tok_last"}, int'(tok_last), 0);
    endtask

    task automatic push_resp(input int lat, input bit found, input int idx, input int len);
        resp_t r;
        r.lat = lat; r.found = found; r.idx = idx; r.len = len;
        script_q.push_back(r);
    endtask

    task automatic run_string(input int len, input bit stall, input bit poke);
        int cnt, held;
        bit released;
        model_ptr = 0; model_len = len; exp_err = 1'b0; starts_seen = 0;
        @(negedge clk);
        start = 1'b1; in_len = LW'(len);
        @(negedge clk);
        start = 1'b0; in_len = LW'($urandom_range(0, 31));
        check("busy_on_start", int'(busy), 1);
        check("err_cleared", int'(err), 0);
        if (len == 0) check("empty_done", int'(done), 1);
        cnt = 0; held = 0; released = 1'b0;
        while (!done && cnt < 5000) begin
            if (poke && cnt == 3) begin
                start = 1'b1; in_len = LW'($urandom_range(1, 16));
            end else begin
                start = 1'b0;
            end
            if (stall && tok_valid && !released) begin
                held++;
                if (held == 10) begin
                    ready_mode = 1; stray_en = 1'b0; released = 1'b1;
                end
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        if (!done) begin
            fail_now("done_timeout");
        end else begin
            if (len > 0) check("done_after_last", cyc - last_hs_cyc, 1);
            check("final_ptr", model_ptr, len);
            check("sb_empty", sb_q.size(), 0);
            check("err_flag", int'(err), int'(exp_err));
            @(negedge clk);
            check("done_pulse", int'(done), 0);
            check("busy_drop", int'(busy), 0);
            check("err_sticky", int'(err), int'(exp_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int cnt, len;
        rst = 1'b1; start = 1'b0; in_len = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two hits covering a 4-symbol string
        push_resp(0, 1'b1, 3, 2);
        push_resp(0, 1'b1, 5, 2);
        run_string(4, 1'b0, 1'b0);
        check("hits_m_starts", starts_seen, 2);

        // all misses
        repeat (3) push_resp(1, 1'b0, 9, 3);
        run_string(3, 1'b0, 1'b0);
        check("miss_m_starts", starts_seen, 3);

        // empty input
        run_string(0, 1'b0, 1'b0);
        check("empty_m_starts", starts_seen, 0);

        // matcher never answers
        push_resp(-1, 1'b0, 0, 0);
        run_string(1, 1'b0, 1'b0);

        // downstream stall with a stray m_done during EMIT
        ready_mode = 0; stray_en = 1'b1;
        push_resp(1, 1'b1, 7, 1);
        push_resp(0, 1'b1, 9, 1);
        run_string(2, 1'b1, 1'b0);
        ready_mode = 1; stray_en = 1'b0;

        // over-long match clamps at in_len
        push_resp(0, 1'b1, 1, 2);
        push_resp(0, 1'b1, 2, 7);
        run_string(5, 1'b0, 1'b0);
        check("clamp_m_starts", starts_seen, 2);

        // random strings, random ready, occasional timeouts and ignored restarts
        ready_mode = 2; allow_timeout = 1'b1;
        for (int i = 0; i < 30; i++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
            run_string(len, 1'b0, (i % 5) == 0);
        end
        ready_mode = 1; allow_timeout = 1'b0;

        // reset while waiting on the matcher
        model_ptr = 0; model_len = 3; exp_err = 1'b0; starts_seen = 0;
        push_resp(0, 1'b1, 6, 1);
        push_resp(-1, 1'b0, 0, 0);
        @(negedge clk);
        start = 1'b1; in_len = LW'(3);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (starts_seen < 2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (starts_seen < 2) fail_now("second_m_start_timeout");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("midrst");
        @(negedge clk);
        sb_q.delete(); script_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // recovery after reset
        run_string(2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
